pulse_profile_gen: RTL and testbench
====================================

# pulse_profile_gen

Parametrised successor to the lab's fixed-rate pulse generator. Produces a square-wave `pulse` whose half-period is either one of three parameter-set fixed rates or taken from a writable step profile. In profile mode the generator advances through up to `PROF_DEPTH` steps, each holding a rate for a programmed number of seconds. It sits between the mode/start controls and the downstream pulse counter and display logic, and also exports the one-second tick.

## Interface
- `HP_W`, 16, width of every half-period value, in clock cycles
- `HP0`, 16, mode 0 half-period
- `HP1`, 32, mode 1 half-period
- `HP2`, 64, mode 2 half-period
- `PROF_DEPTH`, 8, number of profile steps (≥2)
- `SEC_W`, 8, width of the per-step duration in seconds
- `SEC_CYCLES`, 100000000, clock cycles per one-second tick
- `CNT_W`, 16, width of the pulse counter
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: run enable
- `mode` in 2: 0/1/2 select fixed `HP0`/`HP1`/`HP2`; 3 selects profile
- `prof_we` in 1: profile write strobe
- `prof_addr` in clog2(PROF_DEPTH): profile write address
- `prof_hp` in HP_W: step half-period; 0 means silent
- `prof_secs` in SEC_W: step duration; 0 means end-of-profile
- `pulse` out 1: generated waveform
- `tick_1hz` out 1: one-cycle strobe every `SEC_CYCLES` cycles
- `step_idx` out clog2(PROF_DEPTH): current profile step
- `prof_done` out 1: profile finished
- `pulse_cnt` out CNT_W: rising edges of `pulse` since `start` rose; saturates at all-ones

## Operation
- Tick counter is free-running from 0 to `SEC_CYCLES-1`. `tick_1hz` is high for the cycle in which the counter wraps. It is independent of `start`.
- Period engine: the active half-period `hp_act` and phase counter `ph` are used as follows.
  - `start` low: `ph`=0 and the internal track is 0.
  - `start` high with `hp_act`≠0: `ph` increments. At `ph==hp_act-1`, `ph`←0 and the track toggles.
  - `hp_act`==0: the track is forced to 0 and `ph` is held at 0.
  - `pulse` = track AND `start`.
- Rate selection: `hp_sel` is `HPx` in modes 0–2, and in mode 3 it is the current step's `prof_hp` (0 in IDLE/DONE). `hp_act` loads `hp_sel` only at a wrap (`ph==hp_act-1`), when `hp_act`==0, or while `start` is low. This guarantees glitch-free rate changes with no truncated half-periods.
- Profile FSM states are IDLE, RUN and DONE.
  - IDLE→RUN: `mode==3` and `start` high. Sets step 0 and `secs_left`←`prof_secs[0]`. If `prof_secs[0]`==0 the FSM goes directly to DONE.
  - RUN: each `tick_1hz` decrements `secs_left`. A tick with `secs_left==1` advances the step. If the step is the last one (`PROF_DEPTH-1`) or the next `prof_secs` is 0, the FSM goes to DONE instead.
  - DONE: `prof_done`=1 and the half-period selects 0.
  - Any state → IDLE when `mode!=3` or `start` is low. The step index and done flag are cleared.
- Profile RAM: `prof_we` writes on the clock edge. Writes are accepted in any state. A write to the current step's entry takes effect on the next wrap; a duration write takes effect at the next step load only.
- `pulse_cnt` clears on the rising edge of `start` and increments on each 0→1 transition of `pulse`.

## Timing
- Reset values:
  - `pulse`=0, `tick_1hz`=0, `step_idx`=0, `prof_done`=0, `pulse_cnt`=0.
  - FSM=IDLE, tick counter=0, `hp_act`=0.
  - Profile RAM contents are undefined; software must write them before use.
- First `pulse` rise occurs `hp_act` cycles after the first clock edge sampling `start`=1, with `hp_act` loaded that same edge.
- Period is 2·`hp_act` cycles at 50% duty. Rate changes land on the next toggle.
- Step advance happens on the edge where `tick_1hz` is high. The new step's rate appears at the next wrap of the old rate.
- Simultaneous `prof_we` and step advance to the same address: the newly written value is used.
- `rst` mid-run: everything returns to reset values immediately; `pulse` drops asynchronously.

## Configuration
- `PULSE_PROFILE_LOOP_EN` defined: where the FSM would enter DONE after at least one step has run, it instead reloads step 0 and stays in RUN. `prof_done` is never asserted except when `prof_secs[0]`==0.
- `PULSE_PROFILE_LOOP_EN` undefined: the profile terminates in DONE as described under Operation.

## Test plan
All scenarios use `SEC_CYCLES`=100 and `PROF_DEPTH`=4.
- Reset, `mode`=0, `start`=1 → first `pulse` rise 16 cycles later; period 32; `pulse_cnt`=10 after 320 cycles.
- Mode 0→2 switched mid-high-phase → current high phase completes at 16 cycles, then the period is 128; no runt pulse.
- Profile {(8,2),(20,1),(4,0),x}, `mode`=3, `start`=1 → half-period 8 for two ticks, then 20 for one tick, then `prof_done`=1 and `pulse` low. With `PULSE_PROFILE_LOOP_EN` defined, the profile returns to half-period 8 and `prof_done` stays 0.
- `start` dropped mid-step 1, then raised → `step_idx` returns to 0, `pulse_cnt` clears, and the profile restarts from step 0.
- Write step 1 `prof_hp`=6 on the same edge as the step-0→1 advance → step 1 runs at half-period 6.
- Assert `rst` for 1 cycle during RUN → all outputs return to 0 immediately, and `tick_1hz` restarts with 100 cycles to the next strobe.

Source files
------------

// File: rtl/pulse_profile_gen.sv
// rtl/pulse_profile_gen.sv - square-wave generator with fixed rates or a stepped profile; PULSE_PROFILE_LOOP_EN makes the profile repeat
module pulse_profile_gen #(
  parameter int HP_W       = 16,
  parameter int HP0        = 16,
  parameter int HP1        = 32,
  parameter int HP2        = 64,
  parameter int PROF_DEPTH = 8,
  parameter int SEC_W      = 8,
  parameter int SEC_CYCLES = 100000000,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [1:0]                    mode,
  input  logic                          prof_we,
  input  logic [$clog2(PROF_DEPTH)-1:0] prof_addr,
  input  logic [HP_W-1:0]               prof_hp,
  input  logic [SEC_W-1:0]              prof_secs,
  output logic                          pulse,
  output logic                          tick_1hz,
  output logic [$clog2(PROF_DEPTH)-1:0] step_idx,
  output logic                          prof_done,
  output logic [CNT_W-1:0]              pulse_cnt
);

  localparam int AW = $clog2(PROF_DEPTH);
  localparam int TW = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  // profile storage, intentionally not reset
  logic [HP_W-1:0]  hp_mem_q   [PROF_DEPTH];
  logic [SEC_W-1:0] secs_mem_q [PROF_DEPTH];

  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             start_q, start_d;
  logic [HP_W-1:0]  hp_act_q, hp_act_d;
  logic [HP_W-1:0]  ph_q, ph_d;
  logic             track_q, track_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           state_q, state_d;
  logic [AW-1:0]    step_q, step_d;
  logic [SEC_W-1:0] secs_q, secs_d;

  logic             tick;
  logic             start_rise;
  logic             prof_mode;
  logic             last_step;
  logic [AW-1:0]    nxt_idx;
  logic [SEC_W-1:0] rd0_secs, rdn_secs;
  logic [HP_W-1:0]  hp_sel;
  logic             hold, wrap;

  assign tick       = (tick_cnt_q == TW'(SEC_CYCLES - 1));
  assign start_rise = start & ~start_q;
  assign prof_mode  = (mode == 2'd3) & start;
  assign last_step  = (step_q == AW'(PROF_DEPTH - 1));
  assign nxt_idx    = last_step ? '0 : step_q + AW'(1);

  // duration reads see a same-edge write so a step load uses the new value
  assign rd0_secs = (prof_we && prof_addr == '0) ? prof_secs : secs_mem_q[0];
  assign rdn_secs = (prof_we && prof_addr == nxt_idx) ? prof_secs : secs_mem_q[nxt_idx];

  assign pulse     = track_q & start;
  assign tick_1hz  = tick;
  assign step_idx  = step_q;
  assign prof_done = (state_q == ST_DONE);
  assign pulse_cnt = cnt_q;

  // profile RAM write port
  always_ff @(posedge clk) begin
    if (prof_we && (int'(prof_addr) < PROF_DEPTH)) begin
      hp_mem_q[prof_addr]   <= prof_hp;
      secs_mem_q[prof_addr] <= prof_secs;
    end
  end

  // free-running one-second divider
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  // rate requested this cycle; profile rates are only live while stepping
  always_comb begin
    hp_sel = '0;
    case (mode)
      2'd0:    hp_sel = HP_W'(HP0);
      2'd1:    hp_sel = HP_W'(HP1);
      2'd2:    hp_sel = HP_W'(HP2);
      default: hp_sel = (state_q == ST_RUN) ? hp_mem_q[step_q] : '0;
    endcase
  end

  // period engine: rate is latched only at a half-period boundary, and the arming edge restarts the phase
  always_comb begin
    hold     = ~start | start_rise | (hp_act_q == '0);
    wrap     = ~hold & (ph_q == hp_act_q - HP_W'(1));
    hp_act_d = hp_act_q;
    ph_d     = ph_q + HP_W'(1);
    track_d  = track_q;
    if (hold) begin
      hp_act_d = hp_sel;
      ph_d     = '0;
      track_d  = 1'b0;
    end else if (wrap) begin
      hp_act_d = hp_sel;
      ph_d     = '0;
      // a wrap into a silent rate ends low so no one-cycle runt escapes
      track_d  = (hp_sel != '0) ? ~track_q : 1'b0;
    end
  end

  // rising-edge counter of pulse, cleared when start is armed, saturating
  always_comb begin
    cnt_d = cnt_q;
    if (start_rise) begin
      cnt_d = '0;
    end else if (start && track_d && !track_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // profile step sequencer
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    secs_d  = secs_q;
    if (!prof_mode) begin
      state_d = ST_IDLE;
      step_d  = '0;
      secs_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          step_d = '0;
          if (rd0_secs == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            secs_d  = rd0_secs;
          end
        end
        ST_RUN: begin
          if (tick) begin
            if (secs_q == SEC_W'(1)) begin
              if (last_step || rdn_secs == '0) begin
`ifdef PULSE_PROFILE_LOOP_EN
                step_d = '0;
                if (rd0_secs == '0) begin
                  state_d = ST_DONE;
                end else begin
                  secs_d = rd0_secs;
                end
`else
                state_d = ST_DONE;
`endif
              end else begin
                step_d = nxt_idx;
                secs_d = rdn_secs;
              end
            end else begin
              secs_d = secs_q - SEC_W'(1);
            end
          end
        end
        default: state_d = ST_DONE;
      endcase
    end
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      start_q    <= 1'b0;
      hp_act_q   <= '0;
      ph_q       <= '0;
      track_q    <= 1'b0;
      cnt_q      <= '0;
      state_q    <= ST_IDLE;
      step_q     <= '0;
      secs_q     <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      start_q    <= start_d;
      hp_act_q   <= hp_act_d;
      ph_q       <= ph_d;
      track_q    <= track_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      step_q     <= step_d;
      secs_q     <= secs_d;
    end
  end

  assign start_d = start;

endmodule

// File: tb/tb_pulse_profile_gen.sv
// tb/tb_pulse_profile_gen.sv - directed self-checking bench for pulse_profile_gen
module tb_pulse_profile_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic        prof_we;
  logic [1:0]  prof_addr;
  logic [15:0] prof_hp;
  logic [7:0]  prof_secs;
  logic        pulse;
  logic        tick_1hz;
  logic [1:0]  step_idx;
  logic        prof_done;
  logic [15:0] pulse_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int b;
  int rise_last = -1;
  int rise_prev = -1;
  int fall_last = -1;
  int tick_last = -1;
  logic pulse_last = 1'b0;

  pulse_profile_gen #(
    .SEC_CYCLES (100),
    .PROF_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .prof_we   (prof_we),
    .prof_addr (prof_addr),
    .prof_hp   (prof_hp),
    .prof_secs (prof_secs),
    .pulse     (pulse),
    .tick_1hz  (tick_1hz),
    .step_idx  (step_idx),
    .prof_done (prof_done),
    .pulse_cnt (pulse_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // edge recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (pulse && !pulse_last) begin
      rise_prev = rise_last;
      rise_last = cyc;
    end
    if (!pulse && pulse_last) fall_last = cyc;
    pulse_last = pulse;
    if (tick_1hz) tick_last = cyc;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] hp, input logic [7:0] s);
    prof_we   = 1'b1;
    prof_addr = a;
    prof_hp   = hp;
    prof_secs = s;
    @(posedge clk);
    #1;
    prof_we   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0;
    prof_we = 1'b0; prof_addr = '0; prof_hp = '0; prof_secs = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pulse", pulse, 0);
    chk("rst_tick", tick_1hz, 0);
    chk("rst_step", step_idx, 0);
    chk("rst_done", prof_done, 0);
    chk("rst_cnt", pulse_cnt, 0);

    // fixed mode 0 from reset
    rst = 1'b0; start = 1'b1; mode = 2'd0;
    b = cyc + 1;
    wait_cyc(b + 20);
    chk("m0_first_rise", rise_last, b + 16);
    wait_cyc(b + 50);
    chk("m0_rise2", rise_last, b + 48);
    chk("m0_rise1", rise_prev, b + 16);
    wait_cyc(b + 100);
    chk("tick_first", tick_last, b + 98);
    wait_cyc(b + 320);
    chk("m0_cnt_320", pulse_cnt, 10);
    chk("tick_third", tick_last, b + 298);

    // mode 0 -> 2 in the middle of a high phase
    wait_cyc(b + 340);
    chk("m02_high_before", pulse, 1);
    mode = 2'd2;
    wait_cyc(b + 360);
    chk("m02_fall_full", fall_last, b + 352);
    chk("m02_no_runt", rise_last, b + 336);
    wait_cyc(b + 560);
    chk("m2_rise_a", rise_prev, b + 416);
    chk("m2_rise_b", rise_last, b + 544);
    chk("m2_cnt", pulse_cnt, 13);

    // profile {(8,2),(20,1),(4,0),(50,5)}
    start = 1'b0; mode = 2'd3;
    wr(2'd0, 16'd8, 8'd2);
    wr(2'd1, 16'd20, 8'd1);
    wr(2'd2, 16'd4, 8'd0);
    wr(2'd3, 16'd50, 8'd5);
    wait_cyc(b + 600);
    start = 1'b1;
    wait_cyc(b + 602);
    chk("pr_cnt_clr", pulse_cnt, 0);
    wait_cyc(b + 612);
    chk("pr_first_rise", rise_last, b + 610);
    wait_cyc(b + 700);
    chk("pr_s0_rise", rise_last, b + 690);
    chk("pr_s0_per", rise_last - rise_prev, 16);
    chk("pr_s0_idx", step_idx, 0);
    wait_cyc(b + 800);
    chk("pr_s1_idx", step_idx, 1);
    chk("pr_s1_notdone", prof_done, 0);
    wait_cyc(b + 850);
    chk("pr_s1_rise_a", rise_prev, b + 802);
    chk("pr_s1_rise_b", rise_last, b + 842);
`ifdef PULSE_PROFILE_LOOP_EN
    wait_cyc(b + 900);
    chk("loop_notdone", prof_done, 0);
    chk("loop_idx0", step_idx, 0);
    wait_cyc(b + 930);
    chk("loop_rise_a", rise_prev, b + 910);
    chk("loop_rise_b", rise_last, b + 926);
    wait_cyc(b + 1000);
    chk("loop_still_notdone", prof_done, 0);
`else
    wait_cyc(b + 900);
    chk("pr_done", prof_done, 1);
    wait_cyc(b + 910);
    chk("pr_done_fall", fall_last, b + 902);
    chk("pr_done_low", pulse, 0);
    wait_cyc(b + 1000);
    chk("pr_done_low2", pulse, 0);
    chk("pr_done_cnt", pulse_cnt, 15);
`endif

    // drop start and rerun; drop again mid step 1
    start = 1'b0;
    wait_cyc(b + 1001);
    chk("stop_idx", step_idx, 0);
    chk("stop_done", prof_done, 0);
    wait_cyc(b + 1010);
    start = 1'b1;
    wait_cyc(b + 1200);
    chk("rerun_s1", step_idx, 1);
    start = 1'b0;
    wait_cyc(b + 1221);
    chk("mid_drop_idx", step_idx, 0);
    chk("mid_drop_pulse", pulse, 0);
    wait_cyc(b + 1230);
    start = 1'b1;
    wait_cyc(b + 1231);
    chk("restart_cnt_clr", pulse_cnt, 0);
    wait_cyc(b + 1250);
    chk("restart_rise", rise_last, b + 1240);
    chk("restart_cnt", pulse_cnt, 1);
    wait_cyc(b + 1300);
    chk("restart_s0_held", step_idx, 0);

    // rewrite step 1 on the very edge that advances into it
    wait_cyc(b + 1398);
    wr(2'd1, 16'd6, 8'd3);
    wait_cyc(b + 1400);
    chk("wr_adv_idx", step_idx, 1);
    wait_cyc(b + 1430);
    chk("wr_adv_rise_a", rise_prev, b + 1412);
    chk("wr_adv_rise_b", rise_last, b + 1424);
    wait_cyc(b + 1500);
    chk("wr_adv_secs_idx", step_idx, 1);
    chk("wr_adv_secs_done", prof_done, 0);

    // one-cycle reset during RUN
    wait_cyc(b + 1558);
    chk("pre_rst_high", pulse, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_pulse", pulse, 0);
    chk("rst_async_step", step_idx, 0);
    chk("rst_async_done", prof_done, 0);
    chk("rst_async_cnt", pulse_cnt, 0);
    chk("rst_async_tick", tick_1hz, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_cyc(b + 1660);
    chk("tick_after_rst", tick_last, b + 1658);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
